// File: rtl/mod12_seq_pkg.sv
// Shared types and default sizing for the mod-12 count sequencer.
package mod12_seq_pkg;

  localparam int unsigned DEF_MODULUS = 12;
  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DEF_STEP_W  = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mod12_updown_core.sv
// Modulo up/down counter register with load, clear and a registered wrap pulse.
module mod12_updown_core
  import mod12_seq_pkg::*;
#(
  parameter int unsigned MODULUS = DEF_MODULUS,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] count_q;
  logic             wrap_q;

  // Clear beats load beats step; wrap flags only a modular step across the boundary.
  always_ff @(posedge Clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (clr_i) begin
        count_q <= '0;
      end else if (ld_i) begin
        count_q <= ld_val_i;
      end else if (en_i) begin
        if (up_i) begin
          if (count_q == CNT_MAX) begin
            count_q <= '0;
            wrap_q  <= 1'b1;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_q <= CNT_MAX;
            wrap_q  <= 1'b1;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
      end
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/mod12_count_sequencer.sv
// Command sequencer driving a mod-12 up/down counter core.
// Optional abort input enabled by defining SEQ_ABORT_EN.
module mod12_count_sequencer
  import mod12_seq_pkg::*;
#(
  parameter int unsigned MODULUS = DEF_MODULUS,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned STEP_W  = DEF_STEP_W
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
`ifdef SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic [CNT_W-1:0]  Count,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              err
);

  seq_state_e        state_q;
  cmd_op_e           op_q;
  logic [STEP_W-1:0] arg_q;
  logic              done_q;
  logic              err_q;

  logic abort_c;
  logic run_c;
  logic load_ok_c;
  logic step_c;
  logic ld_c;
  logic clr_c;

`ifdef SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Core controls decoded from the latched command; abort suppresses any action that edge.
  assign run_c     = (state_q == S_RUN) && !abort_c;
  assign load_ok_c = (32'(arg_q) < MODULUS);
  assign step_c    = run_c && ((op_q == OP_UP) || (op_q == OP_DOWN)) && (arg_q != '0);
  assign ld_c      = run_c && (op_q == OP_LOAD) && load_ok_c;
  assign clr_c     = run_c && (op_q == OP_CLEAR);

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q <= S_RUN;
            op_q    <= cmd_op_e'(cmd_op);
            arg_q   <= cmd_arg;
          end
        end
        S_RUN: begin
          if (abort_c) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            case (op_q)
              OP_LOAD: begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
                err_q   <= !load_ok_c;
              end
              OP_CLEAR: begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
              end
              OP_UP, OP_DOWN: begin
                // arg_q counts remaining steps; finish on the edge taking the last one.
                if (arg_q == '0) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                end else begin
                  arg_q <= arg_q - STEP_W'(1);
                  if (arg_q == STEP_W'(1)) begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  mod12_updown_core #(
    .MODULUS (MODULUS),
    .CNT_W   (CNT_W)
  ) u_core (
    .Clk      (Clk),
    .reset    (reset),
    .en_i     (step_c),
    .up_i     (op_q == OP_UP),
    .ld_i     (ld_c),
    .ld_val_i (CNT_W'(arg_q)),
    .clr_i    (clr_c),
    .count_o  (Count),
    .wrap_o   (wrap)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mod12_count_sequencer.sv
// Scoreboard bench: stimulus queues expected done/wrap/err events, a monitor checks them.
module tb_mod12_count_sequencer;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_arg = 4'd0;
  logic [3:0] Count;
  logic       busy, done, wrap, err;
`ifdef SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] count;
    logic       wrap;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, CLEAR = 2'b11;

  mod12_count_sequencer dut (
    .Clk       (Clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
`ifdef SEQ_ABORT_EN
    .abort     (abort),
`endif
    .Count     (Count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .err       (err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input int c, input bit w, input bit d, input bit e);
    exp_t x;
    x.count = 4'(c);
    x.wrap  = w;
    x.done  = d;
    x.err   = e;
    return x;
  endfunction

  // Monitor: every cycle presenting done/wrap/err must match the oldest queued event.
  initial begin
    exp_t got, want;
    forever begin
      @(negedge Clk);
      if (done || wrap || err) begin
        got = mk(int'(Count), wrap, done, err);
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'(got), -1);
        end else begin
          want = exp_q.pop_front();
          check("event{count,wrap,done,err}", int'(got), int'(want));
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] arg);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge Clk); #1;
      t++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!cmd_ready && t < 40) begin
      @(posedge Clk); #1;
      t++;
    end
    if (!cmd_ready) check("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [1:0] op, input logic [3:0] arg);
    send(op, arg);
    wait_idle();
  endtask

  initial begin
    // 1: reset, then LOAD 5
    reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 reset = 1'b0;
    check("reset_count", int'(Count), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    exp_q.push_back(mk(5, 0, 1, 0));
    run(LOAD, 4'd5);
    check("load_ready_after", int'(cmd_ready), 1);
    @(posedge Clk); #1;
    check("done_deasserts", int'(done), 0);

    // 2: UP 9 from 5 wraps once, ends at 2
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(2, 0, 1, 0));
    run(UP, 4'd9);

    // 3: DOWN 3 from 1 wraps once, ends at 10
    exp_q.push_back(mk(1, 0, 1, 0));
    run(LOAD, 4'd1);
    exp_q.push_back(mk(11, 1, 0, 0));
    exp_q.push_back(mk(10, 0, 1, 0));
    run(DOWN, 4'd3);

    // 4: bad load and zero-step UP leave Count alone
    exp_q.push_back(mk(10, 0, 1, 1));
    run(LOAD, 4'd13);
    exp_q.push_back(mk(10, 0, 1, 0));
    run(UP, 4'd0);
    check("up0_count", int'(Count), 10);

    // boundaries: LOAD 11, UP 1 wraps on its done edge, DOWN 1 from 0, LOAD 12 rejected
    exp_q.push_back(mk(11, 0, 1, 0));
    run(LOAD, 4'd11);
    exp_q.push_back(mk(0, 1, 1, 0));
    run(UP, 4'd1);
    exp_q.push_back(mk(11, 1, 1, 0));
    run(DOWN, 4'd1);
    exp_q.push_back(mk(11, 0, 1, 1));
    run(LOAD, 4'd12);
    exp_q.push_back(mk(0, 0, 1, 0));
    run(CLEAR, 4'd7);

    // 5: reset mid-run; a command held valid during RUN must be ignored
    send(UP, 4'd8);
    cmd_valid = 1'b1;
    cmd_op    = LOAD;
    cmd_arg   = 4'd7;
    repeat (3) begin
      @(posedge Clk); #1;
    end
    check("run_count_3", int'(Count), 3);
    check("run_busy", int'(busy), 1);
    check("run_not_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    check("midreset_count", int'(Count), 0);
    check("midreset_ready", int'(cmd_ready), 1);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    repeat (12) @(posedge Clk);
    #1 check("midreset_still_0", int'(Count), 0);

`ifdef SEQ_ABORT_EN
    // 6: abort after two steps holds Count and reports an error
    exp_q.push_back(mk(2, 0, 1, 0));
    run(LOAD, 4'd2);
    send(UP, 4'd6);
    repeat (2) begin
      @(posedge Clk); #1;
    end
    check("pre_abort_count", int'(Count), 4);
    abort = 1'b1;
    exp_q.push_back(mk(4, 0, 1, 1));
    @(posedge Clk); #1;
    abort = 1'b0;
    check("abort_ready", int'(cmd_ready), 1);
    check("abort_count", int'(Count), 4);
    repeat (3) @(posedge Clk);
    #1 check("abort_held", int'(Count), 4);
`endif

    repeat (3) @(posedge Clk);
    #1 check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
